// File: rtl/output_deskew_collector.sv
// Output deskew collector: receive end of the systolic array.
// Result lanes leave the PE array staggered (lane i one cycle behind lane i-1).
// Each lane gets a reverse-triangle delay of (LANES-1-i) stages so every lane
// of a row lines up in the same cycle. Aligned rows are pushed into a small
// FIFO and presented on a valid/ready port toward the writeback bus.
//
// Handshake: out_valid is high whenever the FIFO holds at least one row.
// out_data is the head row and stays stable while out_valid is high and
// out_ready is low. A row is transferred on a rising edge where
// out_valid & out_ready. out_valid never depends combinationally on out_ready.

module output_deskew_collector #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          clr,
  input  logic [LANES-1:0]              in_valid,
  input  logic [LANES*DATA_WIDTH-1:0]   in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   row_count,
  output logic                          overflow,
  output logic                          misalign
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int RW = LANES * DATA_WIDTH;

  // Outputs of the per-lane delay lines, aligned to the last lane's timing.
  logic [LANES-1:0] dly_valid;
  logic [RW-1:0]    dly_data;

  // ---------------------------------------------------------------------------
  // Reverse-triangle delay lines. Lane i has LANES-1-i stages; the last lane
  // passes straight through because it already arrives latest.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    localparam int NST = LANES - 1 - i;

    if (NST == 0) begin : g_pass
      assign dly_valid[i]                           = in_valid[i];
      assign dly_data[DATA_WIDTH*i +: DATA_WIDTH]   = in_data[DATA_WIDTH*i +: DATA_WIDTH];
    end else begin : g_dly
      logic [NST-1:0]        v_sr;
      logic [DATA_WIDTH-1:0] d_sr [NST];

      // Shift valid and data one stage per enabled cycle; freeze when enable=0.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_sr <= '0;
          for (int k = 0; k < NST; k++) d_sr[k] <= '0;
        end else if (clr) begin
          v_sr <= '0;
          for (int k = 0; k < NST; k++) d_sr[k] <= '0;
        end else if (enable) begin
          v_sr[0] <= in_valid[i];
          d_sr[0] <= in_data[DATA_WIDTH*i +: DATA_WIDTH];
          for (int k = 1; k < NST; k++) begin
            v_sr[k] <= v_sr[k-1];
            d_sr[k] <= d_sr[k-1];
          end
        end
      end

      assign dly_valid[i]                         = v_sr[NST-1];
      assign dly_data[DATA_WIDTH*i +: DATA_WIDTH] = d_sr[NST-1];
    end
  end

  // ---------------------------------------------------------------------------
  // Align check and FIFO control.
  // A complete row is only considered on enabled cycles; a mix of set and clear
  // lane valids means a row lost a lane somewhere upstream and is discarded.
  // ---------------------------------------------------------------------------
  logic          all_v;
  logic          any_v;
  logic          push_cand;
  logic          mis_evt;
  logic          full;
  logic          pop_ok;
  logic          push_ok;
  logic          drop;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [RW-1:0] mem [FIFO_DEPTH];

  assign all_v     = &dly_valid;
  assign any_v     = |dly_valid;
  assign push_cand = enable & all_v;
  assign mis_evt   = enable & any_v & ~all_v;

  assign full      = (fifo_count == CW'(FIFO_DEPTH));
  assign out_valid = (fifo_count != '0);
  assign pop_ok    = out_valid & out_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok   = push_cand & (~full | pop_ok);
  assign drop      = push_cand & full & ~pop_ok;

  // Head entry drives the output port; zero when nothing is buffered.
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Row storage; contents are only observed through out_valid-gated out_data.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) mem[wr_ptr] <= dly_data;
  end

  // Pointers and occupancy; clr has priority over any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else if (clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Accepted-row counter and sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_count <= '0;
      overflow  <= 1'b0;
      misalign  <= 1'b0;
    end else if (clr) begin
      row_count <= '0;
      overflow  <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      if (push_ok) row_count <= row_count + 16'd1;
      if (drop)    overflow  <= 1'b1;
      if (mis_evt) misalign  <= 1'b1;
    end
  end

endmodule
